// File: rtl/otter_mem_arb.sv
// otter_mem_arb: shares OTTER memory port 2 (data port) between the CPU and a debug/DMA requester.
// Latency: grant is combinational (same cycle as req); read data returns 1 cycle after the read grant.
// Backpressure: the loser sees no grant and holds its request. The CPU has fixed priority, but the
//   debug requester wins a tie after MAX_WAIT consecutive denied cycles.
// Ports: CLK/RST (sync, active-high); cpu_* and dbg_* requester sides (req/we/addr/wdata/size in,
//   gnt/rvalid/rdata out, plus cpu_stall); mem_* side toward the synchronous-read memory.
module otter_mem_arb #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [1:0]        cpu_size,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic [1:0]        dbg_size,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_rden2,
    output logic              mem_we2,
    output logic [ADDR_W-1:0] mem_addr2,
    output logic [DATA_W-1:0] mem_din2,
    output logic [1:0]        mem_size,
    input  logic [DATA_W-1:0] mem_dout2
);

    // Tracks which requester, if any, owns the read data arriving from memory this cycle.
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RET_CPU = 2'd1;
    localparam logic [1:0] RET_DBG = 2'd2;

    localparam logic [3:0] MAX_WAIT_L = 4'(MAX_WAIT);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [3:0] wait_cnt;
    logic       dbg_wins_tie;

    // Debug has waited long enough: it takes the port even if the CPU is requesting.
    assign dbg_wins_tie = (wait_cnt == MAX_WAIT_L);

    // Grants are mutually exclusive by construction and held off entirely during reset.
    assign cpu_gnt   = ~RST & cpu_req & ~(dbg_req & dbg_wins_tie);
    assign dbg_gnt   = ~RST & dbg_req & (~cpu_req | dbg_wins_tie);
    assign cpu_stall = cpu_req & ~cpu_gnt;

    assign mem_rden2 = (cpu_gnt & ~cpu_we) | (dbg_gnt & ~dbg_we);
    assign mem_we2   = (cpu_gnt &  cpu_we) | (dbg_gnt &  dbg_we);
    // With no grant the CPU side drives the bus so it never floats between values.
    assign mem_addr2 = dbg_gnt ? dbg_addr  : cpu_addr;
    assign mem_din2  = dbg_gnt ? dbg_wdata : cpu_wdata;
    assign mem_size  = dbg_gnt ? dbg_size  : cpu_size;

    always_comb begin
        state_nxt = IDLE;
        if (cpu_gnt && !cpu_we) begin
            state_nxt = RET_CPU;
        end else if (dbg_gnt && !dbg_we) begin
            state_nxt = RET_DBG;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state <= state_nxt;
            if (!dbg_req || dbg_gnt) begin
                wait_cnt <= 4'd0;
            end else if (wait_cnt != MAX_WAIT_L) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end

    // RST while a return is due cancels it, so rvalid is gated by RST as well as by state.
    assign cpu_rvalid = ~RST & (state == RET_CPU);
    assign dbg_rvalid = ~RST & (state == RET_DBG);
    assign cpu_rdata  = mem_dout2;
    assign dbg_rdata  = mem_dout2;

endmodule

// File: tb/tb_otter_mem_arb.sv
// tb_otter_mem_arb: directed plus randomized stimulus against a cycle-level reference model;
// expected per-cycle behaviour is queued at stimulus time and popped by an independent monitor.
// Includes a behavioural synchronous-read memory attached to the port-2 side.
module tb_otter_mem_arb;
    localparam int MAX_WAIT = 4;

    logic        CLK;
    logic        RST;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic [1:0]  cpu_size, dbg_size;
    logic        cpu_gnt, cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid;
    logic [31:0] cpu_rdata, dbg_rdata;
    logic        mem_rden2, mem_we2;
    logic [31:0] mem_addr2, mem_din2, mem_dout2;
    logic [1:0]  mem_size;

    otter_mem_arb #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
        .CLK(CLK), .RST(RST),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_size(cpu_size), .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_size(dbg_size), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_rden2(mem_rden2), .mem_we2(mem_we2), .mem_addr2(mem_addr2), .mem_din2(mem_din2),
        .mem_size(mem_size), .mem_dout2(mem_dout2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory attached to the DUT: synchronous read, one cycle latency, word indexed.
    logic [31:0] dmem [64];
    always @(posedge CLK) begin
        if (mem_we2) dmem[mem_addr2[7:2]] <= mem_din2;
        if (mem_rden2) mem_dout2 <= dmem[mem_addr2[7:2]];
    end

    typedef struct {
        bit          cg, dg, st, crv, drv, rd, wr;
        logic [31:0] addr, din, rdata;
        logic [1:0]  size;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    // Reference model state: plain bookkeeping of the arbitration rules.
    logic [31:0] ref_mem [64];
    int          m_denied = 0;    // consecutive cycles debug asked and was refused
    int          m_pend   = 0;    // 0 none, 1 CPU read in flight, 2 debug read in flight
    logic [31:0] m_pend_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
    endtask

    // Apply one cycle of inputs, predict the DUT's behaviour for that cycle, queue the prediction.
    task automatic step(input bit rst, input bit cr, input bit cw, input logic [31:0] ca,
                        input logic [31:0] cd, input logic [1:0] cs, input bit dr, input bit dw,
                        input logic [31:0] da, input logic [31:0] dd, input logic [1:0] ds,
                        output int w);
        exp_t e;
        bit   we_w;
        @(posedge CLK);
        #1;
        RST = rst;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd; cpu_size = cs;
        dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd; dbg_size = ds;
        e = '{default: '0};
        w = 0;
        if (!rst) begin
            if (cr && dr) w = (m_denied == MAX_WAIT) ? 2 : 1;
            else if (cr)  w = 1;
            else if (dr)  w = 2;
        end
        e.cg    = (w == 1);
        e.dg    = (w == 2);
        e.st    = cr && (w != 1);
        e.crv   = !rst && (m_pend == 1);
        e.drv   = !rst && (m_pend == 2);
        e.rdata = m_pend_data;
        e.addr  = (w == 2) ? da : ca;
        e.din   = (w == 2) ? dd : cd;
        e.size  = (w == 2) ? ds : cs;
        we_w    = (w == 2) ? dw : cw;
        e.rd    = (w != 0) && !we_w;
        e.wr    = (w != 0) && we_w;
        if (e.wr) ref_mem[e.addr[7:2]] = e.din;
        if (e.rd) m_pend_data = ref_mem[e.addr[7:2]];
        m_pend = e.rd ? w : 0;
        if (rst || !dr || w == 2) m_denied = 0;
        else if (m_denied < MAX_WAIT) m_denied++;
        exp_q.push_back(e);
    endtask

    // Monitor: pops the prediction for the current cycle and compares what the DUT presents.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("cpu_gnt",    {31'd0, cpu_gnt},    {31'd0, e.cg});
                chk("dbg_gnt",    {31'd0, dbg_gnt},    {31'd0, e.dg});
                chk("cpu_stall",  {31'd0, cpu_stall},  {31'd0, e.st});
                chk("cpu_rvalid", {31'd0, cpu_rvalid}, {31'd0, e.crv});
                chk("dbg_rvalid", {31'd0, dbg_rvalid}, {31'd0, e.drv});
                chk("mem_rden2",  {31'd0, mem_rden2},  {31'd0, e.rd});
                chk("mem_we2",    {31'd0, mem_we2},    {31'd0, e.wr});
                chk("mem_addr2",  mem_addr2, e.addr);
                chk("mem_din2",   mem_din2,  e.din);
                chk("mem_size",   {30'd0, mem_size}, {30'd0, e.size});
                if (e.crv) chk("cpu_rdata", cpu_rdata, e.rdata);
                if (e.drv) chk("dbg_rdata", dbg_rdata, e.rdata);
            end
        end
    end

    initial begin
        int w;
        bit r_cr, r_cw, r_dr, r_dw;
        logic [31:0] r_ca, r_cd, r_da, r_dd;
        logic [1:0]  r_cs, r_ds;

        RST = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_size = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_size = '0;
        for (int i = 0; i < 64; i++) begin
            dmem[i]    = 32'hA5A5_0000 + i;
            ref_mem[i] = 32'hA5A5_0000 + i;
        end
        dmem[4]    = 32'hDEAD_BEEF;
        ref_mem[4] = 32'hDEAD_BEEF;

        // Reset state: nothing granted, nothing valid even with both requesting.
        step(1, 1, 0, 32'h10, 0, 2, 1, 0, 32'h14, 0, 2, w);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, w);

        // CPU read only of 0x10 (0xDEADBEEF).
        step(0, 1, 0, 32'h10, 0, 2, 0, 0, 0, 0, 0, w);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, w);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, w);

        // CPU write and debug read collide; debug wins the next cycle.
        step(0, 1, 1, 32'h30, 32'h1111_2222, 2, 1, 0, 32'h34, 0, 2, w);
        step(0, 0, 0, 0, 0, 0, 1, 0, 32'h34, 0, 2, w);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, w);

        // Starvation bound: CPU requests continuously, debug waits MAX_WAIT cycles.
        for (int i = 0; i < 10; i++) begin
            bit dr;
            dr = (i < 5);
            step(0, 1, 0, 32'h40 + 4 * i, 0, 2, dr, 0, 32'h80, 0, 1, w);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, w);

        // Pipelined reads: CPU then debug, back to back.
        step(0, 1, 0, 32'h18, 0, 2, 0, 0, 0, 0, 0, w);
        step(0, 0, 0, 0, 0, 0, 1, 0, 32'h1C, 0, 2, w);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, w);

        // Reset while a CPU read is returning; grants held off, then clean restart.
        step(0, 1, 0, 32'h10, 0, 2, 1, 0, 32'h24, 0, 2, w);
        step(1, 1, 0, 32'h10, 0, 2, 1, 0, 32'h24, 0, 2, w);
        step(0, 1, 0, 32'h10, 0, 2, 1, 0, 32'h24, 0, 2, w);
        step(0, 0, 0, 0, 0, 0, 1, 0, 32'h24, 0, 2, w);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, w);

        // Debug write then read-back of 0x20.
        step(0, 0, 0, 0, 0, 0, 1, 1, 32'h20, 32'h1234_5678, 2, w);
        step(0, 0, 0, 0, 0, 0, 1, 0, 32'h20, 0, 2, w);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, w);

        // Randomized traffic: requesters hold an ungranted request (occasionally dropping it).
        r_cr = 0; r_dr = 0; w = 0;
        for (int i = 0; i < 600; i++) begin
            if (!(r_cr && w != 1 && $urandom_range(0, 9) != 0)) begin
                r_cr = ($urandom_range(0, 99) < 75);
                r_cw = $urandom_range(0, 1);
                r_ca = 32'($urandom_range(0, 63)) << 2;
                r_cd = $urandom;
                r_cs = 2'($urandom_range(0, 3));
            end
            if (!(r_dr && w != 2 && $urandom_range(0, 19) != 0)) begin
                r_dr = ($urandom_range(0, 99) < 50);
                r_dw = $urandom_range(0, 1);
                r_da = 32'($urandom_range(0, 63)) << 2;
                r_dd = $urandom;
                r_ds = 2'($urandom_range(0, 3));
            end
            step(($urandom_range(0, 99) < 2), r_cr, r_cw, r_ca, r_cd, r_cs,
                 r_dr, r_dw, r_da, r_dd, r_ds, w);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, w);

        repeat (3) @(posedge CLK);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
